// File: rtl/cpu_pkg.sv
// Shared CPU definitions: memory mode encoding, opcodes, fetch states and
// the rule deciding whether an opcode word is followed by an extension word.
package cpu_pkg;

  localparam logic READ_MODE  = 1'b0;
  localparam logic WRITE_MODE = 1'b1;

  localparam logic [3:0] OP_ALU  = 4'd0;
  localparam logic [3:0] OP_LOAD = 4'd1;
  localparam logic [3:0] OP_JUMP = 4'd2;
  localparam logic [3:0] IMM_SEL = 4'hF;

  typedef enum logic [2:0] {
    OP_ADDR  = 3'd0,
    OP_DATA  = 3'd1,
    EXT_ADDR = 3'd2,
    EXT_DATA = 3'd3,
    HOLD     = 3'd4
  } fetch_state_t;

  function automatic logic has_ext_word(input logic [31:0] word);
    logic ext;
    case (word[31:28])
      OP_JUMP: ext = 1'b1;
      OP_LOAD: ext = (word[8:5] == IMM_SEL);
      OP_ALU:  ext = (word[13:10] == IMM_SEL);
      default: ext = 1'b0;
    endcase
    return ext;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Fetches one- or two-word instructions from a registered-read memory and
// presents them as a bundle to the decoder with a valid/ready handshake.
//
// state    | meaning
// OP_ADDR  | opcode address (pc) presented to memory
// OP_DATA  | opcode word returned; capture and decode extension rule
// EXT_ADDR | extension address (pc+1) presented to memory
// EXT_DATA | extension word returned; capture it
// HOLD     | bundle valid, waiting for instr_ready
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] mem_address,
  output logic        mem_mode,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_word,
  output logic [31:0] instr_ext,
  output logic        instr_has_ext,
  output logic [31:0] instr_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target
);

  fetch_state_t state;
  logic [31:0]  pc;

  assign mem_mode    = READ_MODE;
  assign mem_data_in = 32'h0000_0000;
  assign instr_valid = (state == HOLD);
  // Address stays put for the whole addr/data pair so the single read completes.
  assign mem_address = ((state == EXT_ADDR) || (state == EXT_DATA)) ? pc + 32'd1 : pc;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= OP_ADDR;
      pc            <= RESET_PC;
      instr_word    <= 32'h0000_0000;
      instr_ext     <= 32'h0000_0000;
      instr_has_ext <= 1'b0;
      instr_pc      <= 32'h0000_0000;
    end else if (redirect_valid) begin
      pc    <= redirect_target;
      state <= OP_ADDR;
    end else begin
      case (state)
        OP_ADDR: state <= OP_DATA;
        OP_DATA: begin
          instr_word    <= mem_data_out;
          instr_pc      <= pc;
          instr_ext     <= 32'h0000_0000;
          instr_has_ext <= 1'b0;
          state         <= has_ext_word(mem_data_out) ? EXT_ADDR : HOLD;
        end
        EXT_ADDR: state <= EXT_DATA;
        EXT_DATA: begin
          instr_ext     <= mem_data_out;
          instr_has_ext <= 1'b1;
          state         <= HOLD;
        end
        HOLD: begin
          if (instr_ready) begin
            pc    <= pc + 32'd1 + {31'd0, instr_has_ext};
            state <= OP_ADDR;
          end
        end
        default: state <= OP_ADDR;
      endcase
    end
  end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, word address of the first fetch after reset.
REQ-002 clock  input  1  single clock; all state changes on posedge clock.
REQ-003 reset  input  1  asynchronous, active-high reset.
REQ-004 mem_address  output  32  word address presented to the flip-flop memory's address_in.
REQ-005 mem_mode  output  1  memory mode; constant READ (0).
REQ-006 mem_data_in  output  32  memory write data; constant 0.
REQ-007 mem_data_out  input  32  memory read data, valid the cycle after mem_address is presented.
REQ-008 instr_valid  output  1  instruction bundle on instr_* outputs is valid.
REQ-009 instr_ready  input  1  decoder accepts the bundle when instr_valid && instr_ready at posedge.
REQ-010 instr_word  output  32  first (opcode) word.
REQ-011 instr_ext  output  32  extension word (immediate or jump target); 0 when instr_has_ext = 0.
REQ-012 instr_has_ext  output  1  bundle carries an extension word.
REQ-013 instr_pc  output  32  word address of instr_word.
REQ-014 redirect_valid  input  1  execute stage requests a fetch redirect (taken JUMP).
REQ-015 redirect_target  input  32  word address to fetch from; used unmodified.

Function
REQ-016 States: OP_ADDR, OP_DATA, EXT_ADDR, EXT_DATA, HOLD.
REQ-017 mem_address = pc in OP_ADDR/OP_DATA and pc+1 in EXT_ADDR/EXT_DATA; there is one outstanding read, and mem_address is held stable until its data is captured.
REQ-018 OP_ADDR -> OP_DATA unconditionally.
REQ-019 OP_DATA: capture mem_data_out into instr_word; evaluate the extension rule; go to EXT_ADDR if it requires an extension word, otherwise HOLD with instr_ext = 0.
REQ-020 Extension rule: opcode = bits[31:28].
- opcode 2 (JUMP): always has an extension word.
- opcode 1 (LOAD): has one when bits[8:5] == 4'hF.
- opcode 0 (ALU): has one when bits[13:10] == 4'hF.
- Any other opcode: no extension word.
REQ-021 EXT_ADDR -> EXT_DATA unconditionally; EXT_DATA captures mem_data_out into instr_ext, sets instr_has_ext = 1 and goes to HOLD.
REQ-022 instr_valid = 1 only in HOLD; all instr_* outputs are stable while in HOLD.
REQ-023 HOLD with instr_ready = 1: pc <= pc + 1 + instr_has_ext; go to OP_ADDR; instr_valid deasserts the next cycle.
REQ-024 HOLD with instr_ready = 0: remain in HOLD indefinitely.
REQ-025 Latency from OP_ADDR entry to instr_valid: 2 cycles for a one-word instruction, 4 cycles for a two-word instruction.
REQ-026 Redirect has highest priority in every state:
- pc <= redirect_target; next state OP_ADDR; any captured or in-flight word is discarded.
- instr_valid is 0 the next cycle.
REQ-027 Redirect and handshake in the same cycle: the presented bundle counts as accepted; the redirect still wins for the pc.
REQ-028 pc arithmetic is 32-bit modulo: pc+1 from 32'hFFFF_FFFF wraps to 0, and an extension read at the top address wraps to 0.
REQ-029 Out-of-range reads return 0 from memory, and a word of 0 is an ordinary ALU opcode with no extension word; no special handling.
REQ-030 mem_mode never equals WRITE in any state, including during reset.

Reset
REQ-031 While reset is asserted: state = OP_ADDR, pc = RESET_PC, instr_valid = 0, instr_word/instr_ext/instr_pc = 0, instr_has_ext = 0, mem_address = RESET_PC.
REQ-032 Reset asserted mid-instruction aborts it immediately; no partial bundle is ever presented.
REQ-033 The first read is issued in the first cycle after reset deasserts.

Structure
REQ-034 Shared package cpu_pkg holds:
- READ_MODE/WRITE_MODE constants.
- Opcode constants (ALU = 0, LOAD = 1, JUMP = 2) and IMM_SEL = 4'hF.
- The fetch state enum.
- Pure function has_ext_word(word) implementing REQ-020.
REQ-035 No sub-module is needed; the block is a single FSM plus registers.

Verification
REQ-036 Bench connects the block to flip-flop memory (SIZE = 80) and a decoder model with controllable instr_ready.
REQ-037 One-word instruction: mem[0] = 32'h1003c022, ready = 1 -> valid 2 cycles after reset release; word = 32'h1003c022, has_ext = 0, pc = 0; next fetch from address 1.
REQ-038 Two-word instruction: mem[0] = 32'h1003c1e0, mem[1] = 32'h40400000 -> valid after 4 cycles; ext = 32'h40400000; next pc = 2; same for ALU immediate 32'h0004bd21 + 32'h00000001.
REQ-039 Backpressure: hold ready = 0 for 10 cycles in HOLD -> all outputs constant, memory address constant; ready = 1 -> exactly one acceptance.
REQ-040 Redirect: assert redirect_valid with target 32'h30 during EXT_DATA -> next valid bundle has pc = 32'h30, word = mem[48]; the discarded instruction never appears.
REQ-041 Reset mid-fetch and pc wrap:
- Assert reset in EXT_ADDR -> valid = 0 and pc = RESET_PC asynchronously.
- With RESET_PC = 32'hFFFF_FFFF and a JUMP word at that address -> ext is read from address 0.
